// File: rtl/ttc_apb_sequencer.sv
// APB master fronting the triple timer counter. Arbitrates between a host
// configuration requester and an interrupt servicer that reads each timer's
// clear-on-read interrupt register, one APB transfer at a time.
module ttc_apb_sequencer #(
    parameter logic [7:0]  IRQ_BASE    = 8'h54,
    parameter logic [7:0]  IRQ_STRIDE  = 8'h04,
    parameter int unsigned IRQ_HOLDOFF = 2
) (
    input  logic        pclk14,
    input  logic        p_reset14,
    input  logic        cfg_req14,
    input  logic        cfg_write14,
    input  logic [7:0]  cfg_addr14,
    input  logic [31:0] cfg_wdata14,
    output logic        cfg_ack14,
    output logic [31:0] cfg_rdata14,
    input  logic [3:1]  ttc_interrupt14,
    output logic        irq_valid14,
    output logic [1:0]  irq_id14,
    output logic [5:0]  irq_status14,
    output logic        psel14,
    output logic        penable14,
    output logic        pwrite14,
    output logic [7:0]  paddr14,
    output logic [31:0] pwdata14,
    input  logic [31:0] prdata14,
    output logic        busy14
);

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        SETUP  = 2'd1,
        ACCESS = 2'd2,
        DONE   = 2'd3
    } state_t;

    localparam logic [3:0] HOLDOFF_LOAD = 4'(IRQ_HOLDOFF);

    state_t     state;
    logic       src_irq;
    logic [1:0] src_id;
    logic [3:0] holdoff_cnt [1:3];
    logic [3:1] eligible;

    logic       grant;
    logic       grant_irq;
    logic [1:0] grant_id;
    logic [7:0] irq_addr;

    // A timer may be serviced only while its line is high and its holdoff has expired
    always_comb begin
        eligible = '0;
        for (int unsigned i = 1; i <= 3; i++) begin
            eligible[i] = ttc_interrupt14[i] && (holdoff_cnt[i] == 4'd0);
        end
    end

    // Fixed priority: timer 1, timer 2, timer 3, then the config requester
    always_comb begin
        grant     = 1'b0;
        grant_irq = 1'b0;
        grant_id  = 2'd0;
        if (eligible[1]) begin
            grant     = 1'b1;
            grant_irq = 1'b1;
            grant_id  = 2'd1;
        end else if (eligible[2]) begin
            grant     = 1'b1;
            grant_irq = 1'b1;
            grant_id  = 2'd2;
        end else if (eligible[3]) begin
            grant     = 1'b1;
            grant_irq = 1'b1;
            grant_id  = 2'd3;
        end else if (cfg_req14) begin
            grant     = 1'b1;
        end
    end

    // Interrupt register address of the timer being granted
    always_comb begin
        case (grant_id)
            2'd1:    irq_addr = IRQ_BASE;
            2'd2:    irq_addr = IRQ_BASE + IRQ_STRIDE;
            default: irq_addr = IRQ_BASE + 8'(IRQ_STRIDE << 1);
        endcase
    end

    // Transfer FSM; every output is registered and set on entry to its state
    always_ff @(posedge pclk14) begin
        if (p_reset14) begin
            state        <= IDLE;
            src_irq      <= 1'b0;
            src_id       <= 2'd0;
            psel14       <= 1'b0;
            penable14    <= 1'b0;
            pwrite14     <= 1'b0;
            paddr14      <= '0;
            pwdata14     <= '0;
            cfg_ack14    <= 1'b0;
            cfg_rdata14  <= '0;
            irq_valid14  <= 1'b0;
            irq_id14     <= 2'd0;
            irq_status14 <= '0;
            busy14       <= 1'b0;
        end else begin
            cfg_ack14   <= 1'b0;
            irq_valid14 <= 1'b0;
            case (state)
                IDLE: begin
                    if (grant) begin
                        state     <= SETUP;
                        src_irq   <= grant_irq;
                        src_id    <= grant_id;
                        psel14    <= 1'b1;
                        penable14 <= 1'b0;
                        busy14    <= 1'b1;
                        if (grant_irq) begin
                            paddr14  <= irq_addr;
                            pwrite14 <= 1'b0;
                            pwdata14 <= '0;
                        end else begin
                            paddr14  <= cfg_addr14;
                            pwrite14 <= cfg_write14;
                            pwdata14 <= cfg_wdata14;
                        end
                    end
                end
                SETUP: begin
                    state     <= ACCESS;
                    penable14 <= 1'b1;
                end
                ACCESS: begin
                    // No wait states: prdata14 is valid at the end of ACCESS
                    state     <= DONE;
                    psel14    <= 1'b0;
                    penable14 <= 1'b0;
                    if (src_irq) begin
                        irq_valid14  <= 1'b1;
                        irq_id14     <= src_id;
                        irq_status14 <= prdata14[5:0];
                    end else begin
                        cfg_ack14 <= 1'b1;
                        if (!pwrite14) begin
                            cfg_rdata14 <= prdata14;
                        end
                    end
                end
                DONE: begin
                    // cfg_req14 is deliberately not looked at here
                    state  <= IDLE;
                    busy14 <= 1'b0;
                end
                default: begin
                    state  <= IDLE;
                    busy14 <= 1'b0;
                end
            endcase
        end
    end

    // Holdoff counters: loaded as a serviced timer leaves DONE, then count down to 0
    always_ff @(posedge pclk14) begin
        if (p_reset14) begin
            for (int unsigned i = 1; i <= 3; i++) begin
                holdoff_cnt[i] <= '0;
            end
        end else begin
            for (int unsigned i = 1; i <= 3; i++) begin
                if (state == DONE && src_irq && src_id == 2'(i)) begin
                    holdoff_cnt[i] <= HOLDOFF_LOAD;
                end else if (holdoff_cnt[i] != 4'd0) begin
                    holdoff_cnt[i] <= holdoff_cnt[i] - 4'd1;
                end
            end
        end
    end

endmodule

// File: tb/tb_ttc_apb_sequencer.sv
// Scoreboard bench for ttc_apb_sequencer: stimulus pushes expected completions,
// a monitor pops and compares whenever cfg_ack14 or irq_valid14 pulses.
module tb_ttc_apb_sequencer;

    logic        pclk14 = 1'b0;
    logic        p_reset14;
    logic        cfg_req14;
    logic        cfg_write14;
    logic [7:0]  cfg_addr14;
    logic [31:0] cfg_wdata14;
    logic        cfg_ack14;
    logic [31:0] cfg_rdata14;
    logic [3:1]  ttc_interrupt14;
    logic        irq_valid14;
    logic [1:0]  irq_id14;
    logic [5:0]  irq_status14;
    logic        psel14;
    logic        penable14;
    logic        pwrite14;
    logic [7:0]  paddr14;
    logic [31:0] pwdata14;
    logic [31:0] prdata14;
    logic        busy14;

    // Second instance with holdoff disabled
    logic        cfg_ack_h0;
    logic [31:0] cfg_rdata_h0;
    logic [3:1]  int_h0;
    logic        irq_valid_h0;
    logic [1:0]  irq_id_h0;
    logic [5:0]  irq_status_h0;
    logic        psel_h0;
    logic        penable_h0;
    logic        pwrite_h0;
    logic [7:0]  paddr_h0;
    logic [31:0] pwdata_h0;
    logic [31:0] prdata_h0;
    logic        busy_h0;

    logic [31:0] prd54;
    int          cyc = 0;
    int          n_checks = 0;
    int          n_fail = 0;

    typedef struct {
        bit          is_irq;
        int          cyc;
        logic [31:0] rdata;
        logic [1:0]  id;
        logic [5:0]  status;
    } exp_t;

    exp_t exp_q[$];
    exp_t mon_e;

    ttc_apb_sequencer #(
        .IRQ_BASE   (8'h54),
        .IRQ_STRIDE (8'h04),
        .IRQ_HOLDOFF(2)
    ) u_dut (
        .pclk14         (pclk14),
        .p_reset14      (p_reset14),
        .cfg_req14      (cfg_req14),
        .cfg_write14    (cfg_write14),
        .cfg_addr14     (cfg_addr14),
        .cfg_wdata14    (cfg_wdata14),
        .cfg_ack14      (cfg_ack14),
        .cfg_rdata14    (cfg_rdata14),
        .ttc_interrupt14(ttc_interrupt14),
        .irq_valid14    (irq_valid14),
        .irq_id14       (irq_id14),
        .irq_status14   (irq_status14),
        .psel14         (psel14),
        .penable14      (penable14),
        .pwrite14       (pwrite14),
        .paddr14        (paddr14),
        .pwdata14       (pwdata14),
        .prdata14       (prdata14),
        .busy14         (busy14)
    );

    ttc_apb_sequencer #(
        .IRQ_BASE   (8'h54),
        .IRQ_STRIDE (8'h04),
        .IRQ_HOLDOFF(0)
    ) u_dut_h0 (
        .pclk14         (pclk14),
        .p_reset14      (p_reset14),
        .cfg_req14      (1'b0),
        .cfg_write14    (1'b0),
        .cfg_addr14     (8'h00),
        .cfg_wdata14    (32'h0),
        .cfg_ack14      (cfg_ack_h0),
        .cfg_rdata14    (cfg_rdata_h0),
        .ttc_interrupt14(int_h0),
        .irq_valid14    (irq_valid_h0),
        .irq_id14       (irq_id_h0),
        .irq_status14   (irq_status_h0),
        .psel14         (psel_h0),
        .penable14      (penable_h0),
        .pwrite14       (pwrite_h0),
        .paddr14        (paddr_h0),
        .pwdata14       (pwdata_h0),
        .prdata14       (prdata_h0),
        .busy14         (busy_h0)
    );

    always #5 pclk14 = ~pclk14;

    always @(posedge pclk14) cyc <= cyc + 1;

    // TTC slave model: read data only meaningful in ACCESS, garbage otherwise
    always_comb begin
        if (psel14 && penable14) begin
            case (paddr14)
                8'h54:   prdata14 = prd54;
                8'h58:   prdata14 = 32'hAAAA_AA22;
                8'h5C:   prdata14 = 32'h5555_5575;
                8'h20:   prdata14 = 32'h1234_5678;
                default: prdata14 = 32'h0BAD_0000;
            endcase
        end else begin
            prdata14 = 32'hDEAD_BEEF;
        end
    end

    always_comb prdata_h0 = (psel_h0 && penable_h0) ? 32'hFFFF_FF81 : 32'hDEAD_BEEF;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge pclk14);
    endtask

    task automatic push(input bit is_irq, input int c, input logic [31:0] rd,
                        input logic [1:0] id, input logic [5:0] st);
        exp_t e;
        e.is_irq = is_irq;
        e.cyc    = c;
        e.rdata  = rd;
        e.id     = id;
        e.status = st;
        exp_q.push_back(e);
    endtask

    // Wait (bounded) for the config ack, checking bus fields on the way, then drop req
    task automatic wait_cfg_ack(input logic w, input logic [7:0] a, input logic [31:0] d);
        bit got = 0;
        for (int i = 0; i < 40; i++) begin
            @(negedge pclk14);
            if (psel14) begin
                chk("cfg_pwrite", {31'b0, pwrite14}, {31'b0, w});
                chk("cfg_paddr", {24'b0, paddr14}, {24'b0, a});
                if (w) chk("cfg_pwdata", pwdata14, d);
            end
            if (cfg_ack14) begin
                got = 1;
                break;
            end
        end
        cfg_req14 = 1'b0;
        if (!got) chk("cfg_ack_timeout", 32'd0, 32'd1);
    endtask

    // Monitor: pop and compare on every completion pulse
    always @(negedge pclk14) begin
        if (!p_reset14 && (cfg_ack14 || irq_valid14)) begin
            if (exp_q.size() == 0) begin
                n_checks++;
                n_fail++;
                $display("FAIL unexpected_done: got ack=%0b irq_valid=%0b id=%0d expected none (cycle %0d)",
                         cfg_ack14, irq_valid14, irq_id14, cyc);
            end else begin
                mon_e = exp_q.pop_front();
                chk("done_kind", {31'b0, irq_valid14}, {31'b0, mon_e.is_irq});
                chk("done_both", {30'b0, cfg_ack14, irq_valid14},
                    mon_e.is_irq ? 32'd1 : 32'd2);
                chk("done_cycle", 32'(cyc), 32'(mon_e.cyc));
                if (mon_e.is_irq) begin
                    chk("irq_id", {30'b0, irq_id14}, {30'b0, mon_e.id});
                    chk("irq_status", {26'b0, irq_status14}, {26'b0, mon_e.status});
                end else begin
                    chk("cfg_rdata", cfg_rdata14, mon_e.rdata);
                end
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL global_timeout: got no finish expected finish by 300000");
        $fatal(1, "timeout");
    end

    initial begin
        int t;
        p_reset14       = 1'b1;
        cfg_req14       = 1'b0;
        cfg_write14     = 1'b0;
        cfg_addr14      = 8'h00;
        cfg_wdata14     = 32'h0;
        ttc_interrupt14 = 3'b000;
        int_h0          = 3'b000;
        prd54           = 32'h0;

        // Reset state
        tick(3);
        chk("rst_psel", {31'b0, psel14}, 32'd0);
        chk("rst_penable", {31'b0, penable14}, 32'd0);
        chk("rst_pwrite", {31'b0, pwrite14}, 32'd0);
        chk("rst_paddr", {24'b0, paddr14}, 32'd0);
        chk("rst_pwdata", pwdata14, 32'd0);
        chk("rst_cfg_ack", {31'b0, cfg_ack14}, 32'd0);
        chk("rst_cfg_rdata", cfg_rdata14, 32'd0);
        chk("rst_irq_valid", {31'b0, irq_valid14}, 32'd0);
        chk("rst_irq_id", {30'b0, irq_id14}, 32'd0);
        chk("rst_irq_status", {26'b0, irq_status14}, 32'd0);
        chk("rst_busy", {31'b0, busy14}, 32'd0);
        p_reset14 = 1'b0;
        tick(2);

        // 1: config write, SETUP/ACCESS/DONE phases
        t = cyc;
        cfg_req14 = 1'b1; cfg_write14 = 1'b1; cfg_addr14 = 8'h0C; cfg_wdata14 = 32'h0000_00A5;
        push(0, t + 3, 32'h0, 2'd0, 6'h0);
        tick(1);
        chk("t1_setup_psel", {31'b0, psel14}, 32'd1);
        chk("t1_setup_penable", {31'b0, penable14}, 32'd0);
        chk("t1_setup_busy", {31'b0, busy14}, 32'd1);
        chk("t1_setup_paddr", {24'b0, paddr14}, 32'h0C);
        chk("t1_setup_pwdata", pwdata14, 32'h0000_00A5);
        tick(1);
        chk("t1_access_psel", {31'b0, psel14}, 32'd1);
        chk("t1_access_penable", {31'b0, penable14}, 32'd1);
        chk("t1_access_pwrite", {31'b0, pwrite14}, 32'd1);
        wait_cfg_ack(1'b1, 8'h0C, 32'h0000_00A5);
        chk("t1_done_psel", {31'b0, psel14}, 32'd0);
        tick(1);
        chk("t1_idle_busy", {31'b0, busy14}, 32'd0);
        chk("t1_idle_paddr_hold", {24'b0, paddr14}, 32'h0C);
        chk("t1_idle_pwdata_hold", pwdata14, 32'h0000_00A5);
        tick(1);

        // 2: config read, data held after ack
        prd54 = 32'h0000_0013;
        t = cyc;
        cfg_req14 = 1'b1; cfg_write14 = 1'b0; cfg_addr14 = 8'h54; cfg_wdata14 = 32'h0;
        push(0, t + 3, 32'h0000_0013, 2'd0, 6'h0);
        wait_cfg_ack(1'b0, 8'h54, 32'h0);
        tick(3);
        chk("t2_rdata_held", cfg_rdata14, 32'h0000_0013);

        // 3: timers 2 and 3 plus config in the same cycle
        t = cyc;
        ttc_interrupt14 = 3'b110;
        cfg_req14 = 1'b1; cfg_write14 = 1'b0; cfg_addr14 = 8'h20;
        push(1, t + 3, 32'h0, 2'd2, 6'h22);
        push(1, t + 7, 32'h0, 2'd3, 6'h35);
        push(0, t + 11, 32'h1234_5678, 2'd0, 6'h0);
        tick(1);
        chk("t3_irq2_paddr", {24'b0, paddr14}, 32'h58);
        chk("t3_irq2_psel", {31'b0, psel14}, 32'd1);
        chk("t3_irq2_pwrite", {31'b0, pwrite14}, 32'd0);
        chk("t3_irq2_pwdata", pwdata14, 32'd0);
        tick(2);
        ttc_interrupt14 = 3'b100;    // clear-on-read drops timer 2 line
        tick(2);
        chk("t3_irq3_paddr", {24'b0, paddr14}, 32'h5C);
        chk("t3_irq3_psel", {31'b0, psel14}, 32'd1);
        tick(2);
        ttc_interrupt14 = 3'b000;
        wait_cfg_ack(1'b0, 8'h20, 32'h0);
        tick(2);

        // 4: timer 1 held high; holdoff 2 -> every 6 cycles, holdoff 0 -> every 4
        prd54 = 32'hFFFF_FFC1;
        t = cyc;
        ttc_interrupt14 = 3'b001;
        int_h0 = 3'b001;
        push(1, t + 3, 32'h0, 2'd1, 6'h01);
        push(1, t + 9, 32'h0, 2'd1, 6'h01);
        push(1, t + 15, 32'h0, 2'd1, 6'h01);
        push(1, t + 21, 32'h0, 2'd1, 6'h01);
        for (int k = 1; k <= 24; k++) begin
            bit ev;
            tick(1);
            ev = (k == 3 || k == 7 || k == 11 || k == 15 || k == 19);
            chk("t4_h0_irq_valid", {31'b0, irq_valid_h0}, {31'b0, ev});
            if (ev) begin
                chk("t4_h0_irq_id", {30'b0, irq_id_h0}, 32'd1);
                chk("t4_h0_irq_status", {26'b0, irq_status_h0}, 32'h01);
            end
            if (k == 19) int_h0 = 3'b000;
            if (k == 21) ttc_interrupt14 = 3'b000;
        end
        tick(2);

        // 5: timer 2 pulse only while a config write is in ACCESS is not serviced
        t = cyc;
        cfg_req14 = 1'b1; cfg_write14 = 1'b1; cfg_addr14 = 8'h30; cfg_wdata14 = 32'hDEAD_C0DE;
        push(0, t + 3, 32'h1234_5678, 2'd0, 6'h0);
        tick(2);
        chk("t5_access_penable", {31'b0, penable14}, 32'd1);
        ttc_interrupt14 = 3'b010;
        tick(1);
        ttc_interrupt14 = 3'b000;
        chk("t5_done_ack", {31'b0, cfg_ack14}, 32'd1);
        cfg_req14 = 1'b0;
        tick(2);
        chk("t5_no_service_busy", {31'b0, busy14}, 32'd0);
        tick(6);

        // 6: reset during ACCESS aborts; held request restarts from SETUP
        t = cyc;
        cfg_req14 = 1'b1; cfg_write14 = 1'b1; cfg_addr14 = 8'h44; cfg_wdata14 = 32'h0000_0001;
        tick(2);
        chk("t6_access_penable", {31'b0, penable14}, 32'd1);
        p_reset14 = 1'b1;
        tick(1);
        chk("t6_rst_psel", {31'b0, psel14}, 32'd0);
        chk("t6_rst_penable", {31'b0, penable14}, 32'd0);
        chk("t6_rst_busy", {31'b0, busy14}, 32'd0);
        chk("t6_rst_ack", {31'b0, cfg_ack14}, 32'd0);
        chk("t6_rst_cfg_rdata", cfg_rdata14, 32'd0);
        chk("t6_rst_irq_status", {26'b0, irq_status14}, 32'd0);
        p_reset14 = 1'b0;
        push(0, cyc + 3, 32'h0, 2'd0, 6'h0);
        tick(1);
        chk("t6_restart_psel", {31'b0, psel14}, 32'd1);
        chk("t6_restart_penable", {31'b0, penable14}, 32'd0);
        wait_cfg_ack(1'b1, 8'h44, 32'h0000_0001);
        tick(4);

        chk("scoreboard_empty", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
